// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - shared DPLL types, reset defaults and arithmetic helpers
package dpll_pkg;

  typedef enum logic [1:0] {IDLE, SUM, PID, UPDATE} state_t;

  localparam logic [15:0] DAC_INIT_DEFAULT = 16'h9E23;

  function automatic logic [31:0] abs32(input logic signed [31:0] x);
    return x[31] ? 32'(-x) : 32'(x);
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [31:0] x,
                                               input logic signed [31:0] lo,
                                               input logic signed [31:0] hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/dpll_avg_window.sv
// rtl/dpll_avg_window.sv - phase history shift register with registered window sum
module dpll_avg_window #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic signed [W-1:0]              din,
  input  logic                             sum_en,
  output logic signed [W+DEPTH_LOG2-1:0]   sum
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = W + DEPTH_LOG2;

  logic signed [W-1:0]  win [DEPTH];
  logic signed [SW-1:0] total;

  // DEPTH_LOG2 guard bits make the full-window sum overflow-free
  always_comb begin
    total = '0;
    for (int i = 0; i < DEPTH; i++) begin
      total = total + SW'(win[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        win[i] <= '0;
      end
      sum <= '0;
    end else begin
      if (push) begin
        win[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          win[i] <= win[i-1];
        end
      end
      if (sum_en) begin
        sum <= total;
      end
    end
  end

endmodule

// File: rtl/dpll_loop_filter.sv
// rtl/dpll_loop_filter.sv - PI loop filter driving the disciplined-oscillator DAC
module dpll_loop_filter
  import dpll_pkg::*;
#(
  parameter int               PHASE_W    = 16,
  parameter int               FREQ_W     = 32,
  parameter int               DAC_W      = 16,
  parameter int               AVG_LOG2   = 3,
  parameter int               KP_FREQ    = 20,
  parameter int               I_SHIFT    = 4,
  parameter int               PHASE_LIM  = 10,
  parameter int               FREQ_LIM   = 500,
  parameter int               STEP_LIM   = 1000,
  parameter logic [DAC_W-1:0] DAC_INIT   = DAC_INIT_DEFAULT,
  parameter int               LOCK_TOL   = 2,
  parameter int               LOCK_COUNT = 16
) (
  input  logic               clk_200,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [PHASE_W-1:0] phase_err,
  input  logic [FREQ_W-1:0]  freq_err,
  input  logic               hold,
  output logic [DAC_W-1:0]   dac_val,
  output logic               dac_valid,
  output logic [31:0]        pid_out,
  output logic               locked,
  output logic [15:0]        reject_cnt,
  output logic               overrun
);

  localparam int SUM_W = PHASE_W + AVG_LOG2;
  localparam int LC_W  = $clog2(LOCK_COUNT + 1);
  localparam logic signed [31:0] KP_S   = KP_FREQ;
  localparam logic signed [31:0] STEP_S = STEP_LIM;
  localparam logic [LC_W-1:0]    LC_MAX = LC_W'(LOCK_COUNT);

  state_t                   state;
  logic signed [31:0]       phase_last, freq_last, prop;
  logic [LC_W-1:0]          lock_cnt;
  logic signed [SUM_W-1:0]  win_sum;

  logic signed [31:0]       phase_s, freq_s, phase_used, freq_used, prop_next;
  logic signed [31:0]       pid_raw, pid_next;
  logic                     phase_ok, freq_ok, capture;
  logic [1:0]               n_rej;
  logic [16:0]              rej_sum;
  logic [15:0]              rej_next;
  logic [LC_W-1:0]          lock_next;
  logic signed [DAC_W+1:0]  dac_sum;
  logic [DAC_W-1:0]         dac_next;

  always_comb begin
    phase_s    = 32'($signed(phase_err));
    freq_s     = 32'($signed(freq_err));
    phase_ok   = abs32(phase_s) <= 32'(PHASE_LIM);
    freq_ok    = abs32(freq_s) <= 32'(FREQ_LIM);
    phase_used = phase_ok ? phase_s : phase_last;
    freq_used  = freq_ok ? freq_s : freq_last;
    prop_next  = freq_used * KP_S + phase_used;
    capture    = (state == IDLE) && sample_valid && !hold;

    n_rej    = {1'b0, ~phase_ok} + {1'b0, ~freq_ok};
    rej_sum  = {1'b0, reject_cnt} + {15'b0, n_rej};
    rej_next = rej_sum[16] ? 16'hFFFF : rej_sum[15:0];

    lock_next = '0;
    if (abs32(phase_used) <= 32'(LOCK_TOL) && n_rej == 2'd0) begin
      lock_next = (lock_cnt == LC_MAX) ? lock_cnt : lock_cnt + 1'b1;
    end

    pid_raw  = prop + (32'(win_sum) >>> I_SHIFT);
    pid_next = sat32(pid_raw, -STEP_S, STEP_S);

    // |pid_out| <= STEP_LIM keeps the sum inside DAC_W+2 signed bits
    dac_sum = $signed({2'b00, dac_val}) + $signed(pid_out[DAC_W+1:0]);
    if (dac_sum[DAC_W+1])  dac_next = '0;
    else if (dac_sum[DAC_W]) dac_next = '1;
    else                   dac_next = dac_sum[DAC_W-1:0];
  end

  dpll_avg_window #(
    .W          (PHASE_W),
    .DEPTH_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk    (clk_200),
    .reset  (reset),
    .push   (capture),
    .din    ($signed(phase_used[PHASE_W-1:0])),
    .sum_en (state == SUM),
    .sum    (win_sum)
  );

  always_ff @(posedge clk_200 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      phase_last <= '0;
      freq_last  <= '0;
      prop       <= '0;
      lock_cnt   <= '0;
      locked     <= 1'b0;
      reject_cnt <= '0;
      overrun    <= 1'b0;
      pid_out    <= '0;
      dac_val    <= DAC_INIT;
      dac_valid  <= 1'b0;
    end else begin
      dac_valid <= 1'b0;
      if (sample_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (capture) begin
          phase_last <= phase_used;
          freq_last  <= freq_used;
          prop       <= prop_next;
          reject_cnt <= rej_next;
          lock_cnt   <= lock_next;
          locked     <= (lock_next == LC_MAX);
          state      <= SUM;
        end
        SUM: state <= PID;
        PID: begin
          pid_out <= pid_next;
          state   <= UPDATE;
        end
        UPDATE: begin
          if (!hold) begin
            dac_val   <= dac_next;
            dac_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (hold) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpll_loop_filter.sv
// tb/tb_dpll_loop_filter.sv - scoreboard bench for dpll_loop_filter with reference model
module tb_dpll_loop_filter;

  logic        clk_200 = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] phase_err = '0;
  logic [31:0] freq_err = '0;
  logic        hold = 1'b0;
  logic [15:0] dac_val;
  logic        dac_valid;
  logic [31:0] pid_out;
  logic        locked;
  logic [15:0] reject_cnt;
  logic        overrun;

  dpll_loop_filter dut (
    .clk_200      (clk_200),
    .reset        (reset),
    .sample_valid (sample_valid),
    .phase_err    (phase_err),
    .freq_err     (freq_err),
    .hold         (hold),
    .dac_val      (dac_val),
    .dac_valid    (dac_valid),
    .pid_out      (pid_out),
    .locked       (locked),
    .reject_cnt   (reject_cnt),
    .overrun      (overrun)
  );

  always #5 clk_200 = ~clk_200;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int dac;
    int pid;
  } exp_t;
  exp_t exp_q[$];

  int m_win [8];
  int m_plast, m_flast, m_lock, m_rej, m_dac, m_pid;
  bit m_locked, m_over;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int clampi(input int x, input int lo, input int hi);
    return (x < lo) ? lo : (x > hi) ? hi : x;
  endfunction

  function automatic int floor_div16(input int s);
    if (s >= 0) return s / 16;
    return -((-s + 15) / 16);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    foreach (m_win[i]) m_win[i] = 0;
    m_plast = 0; m_flast = 0; m_lock = 0; m_rej = 0;
    m_dac = 'h9E23; m_pid = 0; m_locked = 0; m_over = 0;
  endtask

  task automatic model_sample(input int p, input int f, input bit held);
    int pu, fu, nrej, s;
    exp_t e;
    nrej = 0;
    if (iabs(p) <= 10) pu = p; else begin pu = m_plast; nrej++; end
    if (iabs(f) <= 500) fu = f; else begin fu = m_flast; nrej++; end
    m_plast = pu; m_flast = fu;
    m_rej = (m_rej + nrej > 65535) ? 65535 : m_rej + nrej;
    if (iabs(pu) <= 2 && nrej == 0) m_lock = (m_lock >= 16) ? 16 : m_lock + 1;
    else m_lock = 0;
    m_locked = (m_lock == 16);
    for (int i = 7; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = pu;
    s = 0;
    foreach (m_win[i]) s += m_win[i];
    m_pid = clampi(fu * 20 + pu + floor_div16(s), -1000, 1000);
    if (held) begin
      m_lock = 0;
      m_locked = 0;
    end else begin
      m_dac = clampi(m_dac + m_pid, 0, 65535);
      e.dac = m_dac;
      e.pid = m_pid;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk_200) begin
    if (reset && dac_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_dac_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dac_val", dac_val, e.dac);
        check("pid_at_dac", $signed(pid_out), e.pid);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_dac_val", dac_val, 'h9E23);
    check("rst_pid_out", pid_out, 0);
    check("rst_dac_valid", dac_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_reject_cnt", reject_cnt, 0);
    check("rst_overrun", overrun, 0);
  endtask

  task automatic check_status();
    check("reject_cnt", reject_cnt, m_rej);
    check("locked", locked, m_locked);
    check("overrun", overrun, m_over);
  endtask

  task automatic send(input int p, input int f, input bit held, input bit dbl, input bit abort);
    int prev_pid;
    prev_pid = m_pid;
    @(negedge clk_200);
    sample_valid = 1'b1;
    phase_err = 16'(p);
    freq_err = 32'(f);
    @(posedge clk_200); #1;
    if (dbl) begin
      phase_err = 16'(-p);
      freq_err = 32'(f + 7);
    end else begin
      sample_valid = 1'b0;
    end
    if (held) hold = 1'b1;
    if (!abort) model_sample(p, f, held);
    @(posedge clk_200); #1;
    sample_valid = 1'b0;
    if (dbl) m_over = 1;
    if (abort) begin
      reset = 1'b0;
      #1;
      model_reset();
      check_reset_vals();
      @(negedge clk_200);
      reset = 1'b1;
      repeat (5) @(posedge clk_200);
      #1;
      check_reset_vals();
      return;
    end
    check("pid_before_latency", $signed(pid_out), prev_pid);
    @(posedge clk_200); #1;
    check("pid_latency", $signed(pid_out), m_pid);
    @(posedge clk_200); #1;
    hold = 1'b0;
    repeat (2) @(posedge clk_200);
    #1;
    check_status();
  endtask

  task automatic idle_hold_sample(input int p, input int f);
    @(negedge clk_200);
    hold = 1'b1;
    sample_valid = 1'b1;
    phase_err = 16'(p);
    freq_err = 32'(f);
    @(posedge clk_200); #1;
    sample_valid = 1'b0;
    m_lock = 0;
    m_locked = 0;
    @(negedge clk_200);
    hold = 1'b0;
    repeat (4) @(posedge clk_200);
    #1;
    check_status();
    check("idle_hold_dac", dac_val, m_dac);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_200);
    #1;
    check_reset_vals();
    @(negedge clk_200);
    reset = 1'b1;
    repeat (2) @(posedge clk_200);

    send(3, 0, 0, 0, 0);
    check("t1_dac", dac_val, 'h9E26);
    check("t1_pid", pid_out, 3);

    send(0, 60, 0, 0, 0);
    check("t2_pid_pos_clamp", $signed(pid_out), 1000);
    send(0, -60, 0, 0, 0);
    check("t2_pid_neg_clamp", $signed(pid_out), -1000);

    send(3, 5, 0, 0, 0);
    send(50, 900, 0, 0, 0);
    check("t3_reject_cnt", reject_cnt, 2);

    repeat (30) send(0, 60, 0, 0, 0);
    check("t4_dac_top", dac_val, 'hFFFF);
    repeat (70) send(0, -60, 0, 0, 0);
    check("t4_dac_bottom", dac_val, 0);

    idle_hold_sample(1, 0);
    repeat (15) send(1, 0, 0, 0, 0);
    check("t5_not_yet_locked", locked, 0);
    send(1, 0, 0, 0, 0);
    check("t5_locked", locked, 1);
    send(1, 0, 1, 0, 0);
    check("t5_hold_unlock", locked, 0);
    check("t5_hold_dac_frozen", dac_val, m_dac);

    for (int i = 0; i < 40; i++) begin
      int p, f;
      bit h;
      p = int'($urandom_range(28)) - 14;
      f = int'($urandom_range(1200)) - 600;
      h = ($urandom_range(7) == 0);
      send(p, f, h, 0, 0);
    end

    send(2, 10, 0, 1, 0);
    check("t6_overrun", overrun, 1);
    send(4, 1, 0, 0, 1);
    send(3, 0, 0, 0, 0);

    repeat (4) @(posedge clk_200);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dpll_loop_filter.md
Name: dpll_loop_filter

Overview:
- Parametrised PI loop filter for the GPS-disciplined oscillator DPLL, in the clk_200 domain.
- Sits between the PPS phase/frequency detector and the DAC SPI sequencer.
- Adds four things to the fixed-gain loop:
  - configurable gains, widths and averaging depth
  - outlier rejection with a counter
  - step and DAC saturation
  - holdover input, lock detection and overrun flagging

Parameters:
PHASE_W, 16, width of signed phase error input
FREQ_W, 32, width of signed frequency (count) error input
DAC_W, 16, DAC code width (unsigned)
AVG_LOG2, 3, log2 of integrator window depth (window = 8 samples)
KP_FREQ, 20, integer multiplier applied to frequency error
I_SHIFT, 4, arithmetic right shift applied to window sum
PHASE_LIM, 10, |phase_err| above this is an outlier
FREQ_LIM, 500, |freq_err| above this is an outlier
STEP_LIM, 1000, max |pid_out| per update
DAC_INIT, 16'h9E23, DAC code after reset
LOCK_TOL, 2, |phase| at or below this counts toward lock
LOCK_COUNT, 16, consecutive in-tolerance samples needed to assert locked

Ports:
clk_200  in  1  sole clock
reset  in  1  asynchronous, active-low reset
sample_valid  in  1  one-cycle strobe per PPS; phase_err/freq_err valid this cycle
phase_err  in  PHASE_W  signed phase error (clk_200 ticks)
freq_err  in  FREQ_W  signed ref-clock count error over one PPS
hold  in  1  holdover: freeze DAC, ignore samples
dac_val  out  DAC_W  current DAC code
dac_valid  out  1  one-cycle pulse when dac_val has been updated (drives SPI start)
pid_out  out  32  signed, clamped correction of last update
locked  out  1  loop locked indicator
reject_cnt  out  16  saturating count of rejected outliers
overrun  out  1  sticky; sample_valid arrived while busy

Behaviour:
- Reset (async, reset=0) values:
  - dac_val=DAC_INIT; all other outputs 0.
  - Window, last-accepted phase/freq and lock counter cleared.
  - FSM goes to IDLE.
  - Reset mid-update aborts the update; dac_val returns to DAC_INIT.
- FSM states IDLE -> SUM -> PID -> UPDATE -> IDLE; one edge per state.
- IDLE:
  - On sample_valid=1 and hold=0, capture and go to SUM.
  - On sample_valid with hold=1, do nothing (no capture, no counters, no dac_valid).
- Capture, at the sample_valid edge:
  - phase_used = phase_err if |phase_err|<=PHASE_LIM, else the last accepted phase.
  - freq_used = freq_err if |freq_err|<=FREQ_LIM, else the last accepted freq.
  - Each rejection increments reject_cnt by 1 (both rejected in one sample = +2); saturates at 16'hFFFF.
  - Window shifts; phase_used enters at index 0.
  - prop = freq_used*KP_FREQ + phase_used, 32-bit signed.
- SUM: win_sum = signed sum of all 2^AVG_LOG2 entries, width PHASE_W+AVG_LOG2, no overflow possible.
- PID:
  - pid_out = clamp(prop + (win_sum >>> I_SHIFT), -STEP_LIM, +STEP_LIM).
  - The shift is arithmetic and rounds toward -inf.
- UPDATE:
  - dac_val = dac_val + pid_out, computed in DAC_W+2-bit signed.
  - Result saturates to [0, 2^DAC_W-1].
  - dac_valid=1 for exactly the cycle following the UPDATE edge.
- Latency: sample_valid sampled at edge N; pid_out updates at edge N+2; dac_val and dac_valid at edge N+3.
- sample_valid in a non-IDLE state: sample dropped, overrun set (sticky until reset), FSM unaffected.
- hold=1 during SUM/PID/UPDATE:
  - The UPDATE edge leaves dac_val unchanged.
  - dac_valid is not pulsed.
  - pid_out still updates.
- Lock:
  - Evaluated at capture.
  - |phase_used|<=LOCK_TOL and no rejection: lock_cnt+1, saturating at LOCK_COUNT. Otherwise lock_cnt=0.
  - locked = (lock_cnt==LOCK_COUNT), registered.
  - hold=1 clears lock_cnt and locked immediately.

Decomposition:
- Shared package dpll_pkg holds:
  - FSM state enum (IDLE, SUM, PID, UPDATE)
  - DAC_INIT default
  - saturate/abs helper functions, shared with the phase detector
- One sub-module, dpll_avg_window: parametrised shift-register window plus adder tree, with push strobe and registered sum.

Test Plan:
1. Reset, then one sample phase=3, freq=0:
   - Before the sample: dac_val=16'h9E23, pid_out=0.
   - After: win_sum=3 (3>>>4=0), pid_out=3 at N+2; dac_val=16'h9E26 with dac_valid pulse at N+3.
2. phase=0, freq=60 -> prop=1200 -> pid_out clamped to 1000; dac_val +1000. Repeat with freq=-60 -> -1000.
3. Outlier after an accepted phase=3, freq=5: send phase=50, freq=900 -> uses 3 and 5; reject_cnt=2; lock_cnt reset.
4. DAC saturation:
   - DAC at 16'hFF00, pid_out=+1000 -> dac_val=16'hFFFF.
   - DAC near 0 with a negative step -> dac_val=0.
5. Lock and holdover:
   - 16 samples with phase=1 -> locked rises after the 16th capture.
   - Then hold=1 -> locked=0, dac_val frozen, no dac_valid.
6. Overrun and reset:
   - sample_valid at N and N+1 -> second dropped, overrun=1.
   - reset pulsed during PID -> all outputs at reset values; no dac_valid afterwards.
